adder_pipe_nbit: RTL and testbench

Parametrised, pipelined unsigned adder. Generalises the fixed 4-bit combinational adder to WIDTH bits, split into SEG-bit segments with one register stage per segment. The carry ripples one segment per cycle, so the critical path is a single SEG-bit add. Uses valid/ready handshakes on input and output so it can sit between streaming producers and consumers in the datapath.

---
 rtl/adder_pipe_nbit_if.sv | 40 ++++
 rtl/adder_pipe_nbit.sv | 118 +++++++++++
 tb/tb_adder_pipe_nbit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/adder_pipe_nbit_if.sv
// adder_pipe_nbit_if -- streaming bus for the pipelined adder.
//
// Groups the input beat (in_valid/in_ready, A, B, cin) and the result beat
// (out_valid/out_ready, SUM) of adder_pipe_nbit.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : the adder itself
// Optional macro ADDER_PIPE_SUB_EN adds the per-beat `sub` select.
interface adder_pipe_nbit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
`ifdef ADDER_PIPE_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   SUM;

  modport master (
    output in_valid, A, B, cin,
`ifdef ADDER_PIPE_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, SUM
  );

  modport slave (
    input  in_valid, A, B, cin,
`ifdef ADDER_PIPE_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, SUM
  );
endinterface

// File: rtl/adder_pipe_nbit.sv
// adder_pipe_nbit -- pipelined unsigned adder, WIDTH bits in SEG-bit segments.
//
// One register stage per segment; the carry ripples one segment per cycle so
// the critical path is a single SEG-bit add. Latency is STAGES = WIDTH/SEG
// cycles, throughput one beat per cycle.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high (clears valid and data registers)
//   bus  : adder_pipe_nbit_if.slave
//          in_valid/in_ready, A, B, cin   -> operand beat
//          out_valid/out_ready, SUM       -> result beat, SUM[WIDTH] = carry-out
//
// Flow control: a single global enable en = out_ready | ~out_valid advances
// every stage together (bubbles are not squeezed out); in_ready = en.
//
// Optional macro ADDER_PIPE_SUB_EN: adds bus.sub; a beat with sub=1 computes
// A + ~B + 1 (cin ignored), i.e. A - B with SUM[WIDTH]=1 meaning no borrow.
module adder_pipe_nbit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic              clk,
  input  logic              rst,
  adder_pipe_nbit_if.slave  bus
);

  localparam int unsigned STAGES = WIDTH / SEG;

  if (SEG < 1) begin : g_chk_seg
    $error("adder_pipe_nbit: SEG must be at least 1");
  end
  if (((SEG == 0) ? 0 : (WIDTH % SEG)) != 0) begin : g_chk_div
    $error("adder_pipe_nbit: WIDTH must be a multiple of SEG");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef ADDER_PIPE_SUB_EN
  // Subtract as A + ~B + 1: the forced carry-in replaces cin for this beat.
  assign b_eff   = bus.sub ? ~bus.B : bus.B;
  assign cin_eff = bus.sub | bus.cin;
`else
  assign b_eff   = bus.B;
  assign cin_eff = bus.cin;
`endif

  // Each stage k sees only the operand bits not yet consumed (PW wide, the
  // current segment in the low SEG bits) and accumulates a (k+1)*SEG-bit
  // partial sum, so every stored bit is actually used downstream.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned PW = WIDTH - k * SEG;
    localparam int unsigned SW = (k + 1) * SEG;

    logic [PW-1:0] a_p;
    logic [PW-1:0] b_p;
    logic          c_p;
    logic          v_p;
    logic [SEG:0]  seg_sum;
    logic [SW-1:0] s_d;
    logic          v_q;
    logic          c_q;
    logic [SW-1:0] s_q;

    if (k == 0) begin : g_src
      assign a_p = bus.A;
      assign b_p = b_eff;
      assign c_p = cin_eff;
      assign v_p = bus.in_valid & en;
      assign s_d = seg_sum[SEG-1:0];
    end else begin : g_src
      assign a_p = g_stage[k-1].g_fwd.a_q;
      assign b_p = g_stage[k-1].g_fwd.b_q;
      assign c_p = g_stage[k-1].c_q;
      assign v_p = g_stage[k-1].v_q;
      assign s_d = {seg_sum[SEG-1:0], g_stage[k-1].s_q};
    end

    assign seg_sum = {1'b0, a_p[SEG-1:0]} + {1'b0, b_p[SEG-1:0]}
                   + {{SEG{1'b0}}, c_p};

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_p;
        c_q <= seg_sum[SEG];
        s_q <= s_d;
      end
    end

    // Upper operand segments still waiting for their stage.
    if (k < STAGES - 1) begin : g_fwd
      logic [PW-SEG-1:0] a_q;
      logic [PW-SEG-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_p[PW-1:SEG];
          b_q <= b_p[PW-1:SEG];
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.SUM       = {g_stage[STAGES-1].c_q, g_stage[STAGES-1].s_q};
  assign en            = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready  = en;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// tb_adder_pipe_nbit -- directed self-checking bench for adder_pipe_nbit
// (WIDTH=16, SEG=4, latency 4). Build with +define+ADDER_PIPE_SUB_EN to
// exercise the subtract steps as well.
module tb_adder_pipe_nbit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  adder_pipe_nbit_if #(.WIDTH(16)) bus ();

  adder_pipe_nbit #(.WIDTH(16), .SEG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.cin      = c;
`ifdef ADDER_PIPE_SUB_EN
    bus.sub      = s;
`else
    if (s) $display("note: subtract step skipped in adder-only build");
`endif
  endtask

  logic [15:0] sa [5];
  logic [15:0] sb [5];
  logic [16:0] se [5];
  logic [16:0] bp [5];

  initial begin
    checks = 0;
    errors = 0;
    sa = '{16'd1, 16'd5, 16'd15, 16'd10, 16'd10};
    sb = '{16'd2, 16'd3, 16'd1,  16'd5,  16'd0};
    se = '{17'd3, 17'd8, 17'd16, 17'd15, 17'd10};
    bp = '{17'h10111, 17'h11223, 17'h12333, 17'h13445, 17'h14555};

    // 1. Reset
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_sum", {15'd0, bus.SUM}, 32'h0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst = 1'b0;

    // 2. Single add, latency exactly 4
    drive(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
    chk("single_lat1", {31'd0, bus.out_valid}, 32'd0);
    step();
    chk("single_lat2", {31'd0, bus.out_valid}, 32'd0);
    step();
    chk("single_lat3", {31'd0, bus.out_valid}, 32'd0);
    step();
    chk("single_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("single_sum", {15'd0, bus.SUM}, 32'h00003);
    step();
    chk("single_after", {31'd0, bus.out_valid}, 32'd0);

    // 3. Full carry ripple, back to back
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    step();
    chk("ripple_valid0", {31'd0, bus.out_valid}, 32'd1);
    chk("ripple_sum0", {15'd0, bus.SUM}, 32'h10000);
    step();
    chk("ripple_valid1", {31'd0, bus.out_valid}, 32'd1);
    chk("ripple_sum1", {15'd0, bus.SUM}, 32'h1FFFF);
    step();
    chk("ripple_after", {31'd0, bus.out_valid}, 32'd0);

    // 4. Streaming five beats
    for (int i = 0; i < 8; i++) begin
      if (i < 5) drive(1'b1, sa[i], sb[i], 1'b0, 1'b0);
      else       drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      step();
      if (i >= 3) begin
        chk($sformatf("stream_valid%0d", i - 3), {31'd0, bus.out_valid}, 32'd1);
        chk($sformatf("stream_sum%0d", i - 3), {15'd0, bus.SUM}, {15'd0, se[i-3]});
      end
    end
    step();
    chk("stream_after", {31'd0, bus.out_valid}, 32'd0);

    // 5. Backpressure: fill, stall 3 cycles with a beat waiting, release
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h1111 * 16'(i + 1), 16'hF000, i[0], 1'b0);
      step();
    end
    drive(1'b1, 16'h5555, 16'hF000, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    #1;
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_hold_valid%0d", i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp_hold_sum%0d", i), {15'd0, bus.SUM}, {15'd0, bp[0]});
      chk($sformatf("bp_hold_rdy%0d", i), {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", {31'd0, bus.in_ready}, 32'd1);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("bp_drain_valid%0d", i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp_drain_sum%0d", i), {15'd0, bus.SUM}, {15'd0, bp[i]});
      step();
    end
    chk("bp_after", {31'd0, bus.out_valid}, 32'd0);

    // 6a. Reset mid-flight discards in-flight beats
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0100, 16'h0200, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_sum", {15'd0, bus.SUM}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("midrst_valid%0d", i), {31'd0, bus.out_valid}, 32'd0);
      step();
    end

    // 6b. Zero sum still reports a valid result
    drive(1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    step();
    step();
    chk("zero_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("zero_sum", {15'd0, bus.SUM}, 32'h0);
    step();

`ifdef ADDER_PIPE_SUB_EN
    // 6c. Subtract, mixed with an add; cin=1 must be ignored on sub beats
    drive(1'b1, 16'd5, 16'd7, 1'b1, 1'b1);
    step();
    drive(1'b1, 16'd7, 16'd5, 1'b0, 1'b1);
    step();
    drive(1'b1, 16'd7, 16'd5, 1'b1, 1'b0);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("sub_lt_sum", {15'd0, bus.SUM}, 32'h0FFFE);
    step();
    chk("sub_gt_sum", {15'd0, bus.SUM}, 32'h10002);
    step();
    chk("sub_mix_add", {15'd0, bus.SUM}, 32'h0000D);
    chk("sub_mix_valid", {31'd0, bus.out_valid}, 32'd1);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
